vga_timing: RTL
===============

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch; H_TOTAL = sum of the four horizontal parameters = 800.
REQ-005 Parameter V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33; V_TOTAL = 525.
REQ-006 Parameter PIPE_DELAY, 1, pixel-source latency in pix_ce ticks, legal range 1..4.
REQ-007 clock  input  1  single system clock; all logic on its rising edge.
REQ-008 resetn  input  1  asynchronous, active-low reset.
REQ-009 pix_ce  input  1  pixel tick; tie to 1 when clock is the pixel clock.
REQ-010 hcount  output  10  current pixel column, 0..H_TOTAL-1, to pixel sources.
REQ-011 vcount  output  10  current line, 0..V_TOTAL-1, to pixel sources.
REQ-012 enable  output  1  high when hcount < H_ACTIVE and vcount < V_ACTIVE.
REQ-013 frame_start  output  1  one-clock pulse when counters enter (0,0).
REQ-014 red_in / green_in / blue_in  input  3/3/2  RGB332 from the pixel source, PIPE_DELAY ticks behind hcount/vcount.
REQ-015 vga_r / vga_g / vga_b  output  3/3/2  RGB332 to the DAC pins.
REQ-016 vga_hs / vga_vs  output  1/1  sync pins, active low.

Function
REQ-017 All outputs SHALL be registered; counters and outputs change only on clock edges where pix_ce = 1.
REQ-018 hcount SHALL increment by 1 per tick and wrap from H_TOTAL-1 to 0; vcount SHALL increment only on that wrap.
REQ-019 vcount SHALL wrap from V_TOTAL-1 to 0 on the same tick that hcount wraps.
REQ-020 enable, the internal hsync and the internal vsync SHALL be decoded from the next counter values, so all three are valid in the same cycle as hcount/vcount.
REQ-021 Internal hsync SHALL be 0 for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], which is 656..751, and 1 otherwise.
REQ-022 Internal vsync SHALL be 0 for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], which is 490..491, and 1 otherwise.
REQ-023 frame_start SHALL be 1 for exactly one clock, on the tick where hcount and vcount both become 0; it is 0 on all other clocks, including clocks where pix_ce = 0.
REQ-024 The block SHALL pass enable, hsync and vsync through a PIPE_DELAY-stage shift register that advances only on pix_ce.
REQ-025 vga_hs and vga_vs SHALL be the delayed syncs.
REQ-026 vga_r/g/b SHALL register red_in/green_in/blue_in when the delayed enable is 1, and SHALL be 0 otherwise; this blanking forces black even if the source holds a stale colour.
REQ-027 When pix_ce = 0 for any number of cycles, all counters, pipeline stages and outputs SHALL hold.
REQ-028 Counter arithmetic SHALL be 10-bit unsigned; parameter totals above 1024 are illegal and need no handling.

Reset
REQ-029 While resetn = 0, the block SHALL force these values: hcount = H_TOTAL-1 (799), vcount = V_TOTAL-1 (524), enable = 0, frame_start = 0.
REQ-030 While resetn = 0, the internal syncs and every delay stage SHALL be 1/1/0 (hs/vs/enable), vga_hs = vga_vs = 1, and vga_r/g/b = 0.
REQ-031 Assertion of resetn = 0 SHALL take effect immediately, without a clock edge, including mid-line or mid-frame.
REQ-032 The first pix_ce tick after resetn rises SHALL wrap the counters to (0,0), assert frame_start and set enable = 1.

Verification
REQ-033 Release reset, pix_ce = 1 -> first edge gives hcount = 0, vcount = 0, frame_start = 1, enable = 1; the next edge gives frame_start = 0.
REQ-034 Run one full line -> enable falls when hcount = 640; hsync is low for exactly 96 ticks starting at hcount = 656; vcount becomes 1 when hcount wraps 799 -> 0.
REQ-035 Run two full frames -> frame_start pulses exactly once per 420000 ticks; vga_vs is low for 1600 ticks, starting PIPE_DELAY ticks after vcount = 490, hcount = 0.
REQ-036 Drive red_in/green_in/blue_in = 7/7/3 constantly -> vga_r/g/b = 7/7/3 only on delayed-active pixels and 0/0/0 during blanking; the first coloured pixel of a frame appears PIPE_DELAY + 1 clocks after frame_start.
REQ-037 pix_ce toggling 1,0,0,1 -> hcount advances by exactly 2 over the 4 clocks, and all outputs hold on the 0 cycles.
REQ-038 Pull resetn low at hcount = 300, vcount = 200 -> outputs immediately show 799/524, enable = 0, syncs = 1 and RGB = 0; after release, REQ-033 behaviour repeats.

Source files
------------

// File: rtl/vga_timing_if.sv
// Pixel-source and DAC-side signal bundle for the VGA timing generator.
// The master side is the timing generator; the slave side is the pixel source and display.
interface vga_timing_if;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       enable;
    logic       frame_start;
    logic [2:0] red_in;
    logic [2:0] green_in;
    logic [1:0] blue_in;
    logic [2:0] vga_r;
    logic [2:0] vga_g;
    logic [1:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;

    modport master (
        output hcount, vcount, enable, frame_start,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs,
        input  red_in, green_in, blue_in
    );

    modport slave (
        input  hcount, vcount, enable, frame_start,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs,
        output red_in, green_in, blue_in
    );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator with a configurable pixel-source latency pipeline.
// Counters, enable and syncs are decoded from next-state values so they line up with hcount/vcount.
module vga_timing #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          pix_ce,
    vga_timing_if.master  bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] hcount;
    logic [9:0] vcount;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_wrap;
    logic       frame_start;

    // Bit 0 of each pipe is the undelayed decode; bit PIPE_DELAY is the fully delayed stage.
    logic [PIPE_DELAY:0] hs_pipe;
    logic [PIPE_DELAY:0] vs_pipe;
    logic [PIPE_DELAY:0] en_pipe;

    logic [2:0] r_q;
    logic [2:0] g_q;
    logic [1:0] b_q;

    always_comb begin
        h_wrap = (hcount == H_LAST);
        h_next = h_wrap ? '0 : hcount + 10'd1;
        v_next = vcount;
        if (h_wrap) begin
            v_next = (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hcount      <= H_LAST;
            vcount      <= V_LAST;
            frame_start <= 1'b0;
            hs_pipe     <= '1;
            vs_pipe     <= '1;
            en_pipe     <= '0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
        end else begin
            // Pulse lasts one clock even when the next cycle has pix_ce low.
            frame_start <= pix_ce && (h_next == '0) && (v_next == '0);
            if (pix_ce) begin
                hcount  <= h_next;
                vcount  <= v_next;
                hs_pipe <= {hs_pipe[PIPE_DELAY-1:0], !((h_next >= HS_FIRST) && (h_next <= HS_LAST))};
                vs_pipe <= {vs_pipe[PIPE_DELAY-1:0], !((v_next >= VS_FIRST) && (v_next <= VS_LAST))};
                en_pipe <= {en_pipe[PIPE_DELAY-1:0], (h_next < H_VIS) && (v_next < V_VIS)};
                if (en_pipe[PIPE_DELAY]) begin
                    r_q <= bus.red_in;
                    g_q <= bus.green_in;
                    b_q <= bus.blue_in;
                end else begin
                    r_q <= '0;
                    g_q <= '0;
                    b_q <= '0;
                end
            end
        end
    end

    assign bus.hcount      = hcount;
    assign bus.vcount      = vcount;
    assign bus.enable      = en_pipe[0];
    assign bus.frame_start = frame_start;
    assign bus.vga_hs      = hs_pipe[PIPE_DELAY];
    assign bus.vga_vs      = vs_pipe[PIPE_DELAY];
    assign bus.vga_r       = r_q;
    assign bus.vga_g       = g_q;
    assign bus.vga_b       = b_q;
endmodule
